// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx and top_TX: FSM states,
// legal prescale values, parity types and the 2-of-3 vote helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling timer: edge_cnt runs 0..P-1, RX is captured at
// P/2-1, P/2, P/2+1 and majority-voted; the vote is usable from P/2+2.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               rx,
  input  logic [PRESC_W-1:0] presc,
  output logic               sampled_bit,
  output logic               bit_done,
  output logic               vote_ready
);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] half;
  logic [2:0]         smp;

  assign half        = presc >> 1;
  assign bit_done    = (edge_cnt == presc - PRESC_W'(1));
  assign vote_ready  = (edge_cnt == half + PRESC_W'(2));
  assign sampled_bit = majority3(smp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
    end else if (clr || bit_done) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

  // Samples reset to the idle line level so a stale vote never reads as 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp <= '1;
    end else begin
      if (edge_cnt == half - PRESC_W'(1)) smp[0] <= rx;
      if (edge_cnt == half)               smp[1] <= rx;
      if (edge_cnt == half + PRESC_W'(1)) smp[2] <= rx;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first deserialiser, parity/stop checks.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchroniser.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  Par_EN,
  input  logic                  Par_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output uart_state_e           state_dbg
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e          state, state_n;
  logic                 rx;
  logic                 start_now, cnt_clr;
  logic                 sampled_bit, bit_done, vote_ready;
  logic [PRESC_W-1:0]   presc_dec, p_lat;
  logic                 par_en_q, par_typ_q, par_bad, exp_par;
  logic [DATA_WIDTH-1:0] data_sr;
  logic [BCW-1:0]       bit_cnt;
  logic                 last_bit;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], RX_IN};
  end
  assign rx = sync_q[1];
`else
  assign rx = RX_IN;
`endif

  // Any prescale other than 16 or 32 runs at 8.
  always_comb begin
    presc_dec = PRESC_W'(PRESC_8);
    if (Prescale == PRESC_W'(PRESC_16)) presc_dec = PRESC_W'(PRESC_16);
    if (Prescale == PRESC_W'(PRESC_32)) presc_dec = PRESC_W'(PRESC_32);
  end

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .rx          (rx),
    .presc       (p_lat),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done),
    .vote_ready  (vote_ready)
  );

  assign last_bit  = (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign exp_par   = (par_typ_q == PAR_ODD) ? ~^data_sr : ^data_sr;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // A low line at the end of STOP starts the next frame without an idle cycle.
  always_comb begin
    state_n   = state;
    start_now = 1'b0;
    cnt_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx) begin
          state_n   = START;
          start_now = 1'b1;
        end
      end
      START: begin
        if (vote_ready && sampled_bit) begin
          state_n = IDLE;
          cnt_clr = 1'b1;
        end else if (bit_done) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_done && last_bit) state_n = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_done) state_n = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (!rx) begin
            state_n   = START;
            start_now = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_lat      <= PRESC_W'(PRESC_8);
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      data_sr    <= '0;
      bit_cnt    <= '0;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (start_now) begin
        p_lat     <= presc_dec;
        par_en_q  <= Par_EN;
        par_typ_q <= Par_TYP;
        bit_cnt   <= '0;
        par_bad   <= 1'b0;
      end
      if (state == DATA && bit_done) begin
        data_sr <= {sampled_bit, data_sr[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + BCW'(1);
      end
      if (state == PARITY && bit_done) par_bad <= (sampled_bit != exp_par);
      if (state == STOP && bit_done) begin
        stp_err <= ~sampled_bit;
        par_err <= par_bad;
        if (sampled_bit && !par_bad) begin
          data_valid <= 1'b1;
          P_DATA     <= data_sr;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames at each prescale, parity and stop
// errors, glitch rejection, back-to-back frames and mid-frame reset.
module tb_uart_rx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX_IN;
  logic [5:0]  Prescale;
  logic        Par_EN;
  logic        Par_TYP;
  logic [7:0]  P_DATA;
  logic        data_valid, par_err, stp_err, busy;
  uart_state_e state_dbg;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  int dv_n    = 0;
  int pe_n    = 0;
  int se_n    = 0;
  int dv0, pe0, se0;
  int got_rd  = 0;
  int t_start;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         dv_cyc_q[$];

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .Par_EN     (Par_EN),
    .Par_TYP    (Par_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (data_valid) begin
      dv_n <= dv_n + 1;
      got_q.push_back(P_DATA);
      dv_cyc_q.push_back(cyc);
    end
    if (par_err) pe_n <= pe_n + 1;
    if (stp_err) se_n <= se_n + 1;
  end

  // Driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(posedge clk);
    #1;
  endtask

  // Config inputs are scrambled after the start bit; the DUT must ignore them.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic ptyp, input logic pbit, input logic sbit);
    Prescale = 6'(p);
    Par_EN   = pen;
    Par_TYP  = ptyp;
    send_bit(1'b0, p);
    Prescale = 6'($urandom_range(0, 63));
    Par_EN   = ~pen;
    Par_TYP  = ~ptyp;
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pen) send_bit(pbit, p);
    send_bit(sbit, p);
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulses(input string tag, input int dv, input int pe, input int se);
    check({tag, "_dv_cnt"}, dv_n - dv0, dv);
    check({tag, "_pe_cnt"}, pe_n - pe0, pe);
    check({tag, "_se_cnt"}, se_n - se0, se);
    dv0 = dv_n;
    pe0 = pe_n;
    se0 = se_n;
  endtask

  // Scoreboard: compare received bytes against the expected queue
  task automatic score(input string tag);
    check({tag, "_n"}, got_q.size() - got_rd, exp_q.size());
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      check({tag, "_data"}, got_q[got_rd], exp_q.pop_front());
      got_rd++;
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  initial begin
    rst      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    Par_EN   = 1'b0;
    Par_TYP  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pdata", P_DATA, 8'h00);
    check("rst_dv", data_valid, 1'b0);
    check("rst_pe", par_err, 1'b0);
    check("rst_se", stp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b1;
    idle(4);
    dv0 = dv_n; pe0 = pe_n; se0 = se_n;

    // P=8, even parity, 0xA5 with correct parity 0
    t_start = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 8, 1'b1, PAR_EVEN, 1'b0, 1'b1);
    idle(4);
    expect_pulses("t1", 1, 0, 0);
    check("t1_latency", (dv_cyc_q[got_rd] - t_start >= 88 &&
                         dv_cyc_q[got_rd] - t_start <= 90), 1'b1);
    score("t1");
    check("t1_pdata", P_DATA, 8'hA5);
    check("t1_busy", busy, 1'b0);

    // P=16, odd parity, 0xA5 with parity bit 0 -> parity error
    send_frame(8'hA5, 16, 1'b1, PAR_ODD, 1'b0, 1'b1);
    idle(4);
    expect_pulses("t2", 0, 1, 0);
    score("t2");
    check("t2_pdata", P_DATA, 8'hA5);

    // P=32, no parity, 0x3C with stop 0, then good 0x81
    send_frame(8'h3C, 32, 1'b0, PAR_EVEN, 1'b0, 1'b0);
    idle(4);
    expect_pulses("t3a", 0, 0, 1);
    score("t3a");
    check("t3a_pdata", P_DATA, 8'hA5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 32, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    idle(4);
    expect_pulses("t3b", 1, 0, 0);
    score("t3b");
    check("t3b_pdata", P_DATA, 8'h81);

    // P=8, two-cycle glitch on the line
    Prescale = 6'd8;
    Par_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RX_IN = 1'b1;
    @(negedge clk);
    check("t4_busy_hi", busy, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_busy_lo", busy, 1'b0);
    check("t4_state", 32'(state_dbg), 32'(IDLE));
    idle(2);
    expect_pulses("t4", 0, 0, 0);

    // Back-to-back 0x55, 0xAA at P=16, no parity
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 16, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    send_frame(8'hAA, 16, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    idle(4);
    expect_pulses("t5", 2, 0, 0);
    if (dv_cyc_q.size() >= got_rd + 2)
      check("t5_spacing", dv_cyc_q[got_rd+1] - dv_cyc_q[got_rd], 160);
    else
      check("t5_spacing_n", dv_cyc_q.size() - got_rd, 2);
    score("t5");
    check("t5_pdata", P_DATA, 8'hAA);

    // Reset during DATA of 0xFF, then receive 0x12
    Prescale = 6'd8;
    Par_EN   = 1'b0;
    send_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 8);
    check("t6_busy_pre", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_pdata", P_DATA, 8'h00);
    check("t6_busy", busy, 1'b0);
    check("t6_dv", data_valid, 1'b0);
    check("t6_state", 32'(state_dbg), 32'(IDLE));
    RX_IN = 1'b1;
    #3;
    rst = 1'b1;
    idle(20);
    expect_pulses("t6a", 0, 0, 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1);
    idle(4);
    expect_pulses("t6b", 1, 0, 0);
    score("t6b");
    check("t6b_pdata", P_DATA, 8'h12);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
